acp_mm2s_engine: RTL and testbench

Command-driven read engine on the ACP read channel: accepts 72-bit datamover-format commands from an `axi4_stream_master`, fetches the described buffer with AXI4 INCR bursts, and emits it as a 64-bit AXI stream to the custom hardware. It also returns one 8-bit status per command. It is the responder at the far end of the command/status interface, a lightweight in-house replacement for the MM2S half of `xlnx_axi_datamover`.

---
 rtl/acp_mm2s_engine.sv | 149 ++++++++++++++
 tb/tb_acp_mm2s_engine.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acp_mm2s_engine.sv
// MM2S read engine: turns datamover-format commands into 4 KB-safe AXI4 INCR bursts on the
// ACP read channel and streams the returned data out with zero latency, one status per command.
module acp_mm2s_engine #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_MAX_BURST        = 16,
  parameter logic [2:0]  C_PROT             = 3'b010,
  parameter logic [3:0]  C_CACHE            = 4'b1111
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [71:0]                     S_AXIS_CMD_TDATA,
  input  logic                            S_AXIS_CMD_TVALID,
  output logic                            S_AXIS_CMD_TREADY,
  output logic [7:0]                      M_AXIS_STS_TDATA,
  output logic                            M_AXIS_STS_TVALID,
  input  logic                            M_AXIS_STS_TREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY
);

  typedef enum logic [2:0] {StIdle, StCheck, StAddr, StData, StStatus} state_e;

  state_e                          state_q, state_d;
  logic [22:0]                     btt_q;
  logic                            typ_q, eof_q;
  logic [3:0]                      tag_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [19:0]                     beats_left_q;
  logic [8:0]                      burst_q, beat_cnt_q;
  logic                            slverr_q, decerr_q, interr_q;

  logic       cmd_hs, ar_hs, r_hs, burst_done, cmd_bad;
  logic [9:0] page_beats;
  logic [8:0] cap, burst_c;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                             S_AXIS_CMD_TDATA[29:24]};

  assign cmd_hs     = S_AXIS_CMD_TREADY && S_AXIS_CMD_TVALID;
  assign ar_hs      = (state_q == StAddr) && M_AXI_ARREADY;
  assign r_hs       = (state_q == StData) && M_AXI_RVALID && M_AXIS_TREADY;
  assign burst_done = r_hs && (beat_cnt_q == 9'd1);
  assign cmd_bad    = (btt_q == 23'd0) || (btt_q[2:0] != 3'd0) || (addr_q[2:0] != 3'd0) || !typ_q;

  // Beats left before the next 4 KB boundary; addr is 8-byte aligned once past CHECK.
  assign page_beats = 10'd512 - 10'(addr_q[11:3]);
  assign cap        = (page_beats > 10'(C_MAX_BURST)) ? 9'(C_MAX_BURST) : page_beats[8:0];
  assign burst_c    = (beats_left_q > 20'(cap)) ? cap : beats_left_q[8:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_hs) state_d = StCheck;
      StCheck:  state_d = cmd_bad ? StStatus : StAddr;
      StAddr:   if (M_AXI_ARREADY) state_d = StData;
      StData:   if (burst_done) state_d = (beats_left_q == 20'd1) ? StStatus : StAddr;
      StStatus: if (M_AXIS_STS_TREADY) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btt_q        <= '0;
      typ_q        <= 1'b0;
      eof_q        <= 1'b0;
      tag_q        <= '0;
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      slverr_q     <= 1'b0;
      decerr_q     <= 1'b0;
      interr_q     <= 1'b0;
    end else begin
      if (cmd_hs) begin
        btt_q    <= S_AXIS_CMD_TDATA[22:0];
        typ_q    <= S_AXIS_CMD_TDATA[23];
        eof_q    <= S_AXIS_CMD_TDATA[30];
        addr_q   <= C_M_AXI_ADDR_WIDTH'(S_AXIS_CMD_TDATA[63:32]);
        tag_q    <= S_AXIS_CMD_TDATA[67:64];
        slverr_q <= 1'b0;
        decerr_q <= 1'b0;
        interr_q <= 1'b0;
      end
      if (state_q == StCheck) begin
        if (cmd_bad) interr_q <= 1'b1;
        else         beats_left_q <= btt_q[22:3];
      end
      if (ar_hs) begin
        burst_q    <= burst_c;
        beat_cnt_q <= burst_c;
      end
      if (r_hs) begin
        beat_cnt_q   <= beat_cnt_q - 9'd1;
        beats_left_q <= beats_left_q - 20'd1;
        if (M_AXI_RRESP == 2'b10) slverr_q <= 1'b1;
        if (M_AXI_RRESP == 2'b11) decerr_q <= 1'b1;
        // Errors never abort: the burst length is trusted over RLAST.
        if (M_AXI_RLAST != (beat_cnt_q == 9'd1)) interr_q <= 1'b1;
        if (burst_done) addr_q <= addr_q + C_M_AXI_ADDR_WIDTH'({burst_q, 3'b000});
      end
    end
  end

  assign S_AXIS_CMD_TREADY = (state_q == StIdle) && !rst;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = (state_q == StAddr) ? 8'(burst_c - 9'd1) : 8'd0;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARPROT  = C_PROT;
  assign M_AXI_ARCACHE = C_CACHE;
  assign M_AXI_ARVALID = (state_q == StAddr);

  assign M_AXI_RREADY  = (state_q == StData) && M_AXIS_TREADY;
  assign M_AXIS_TVALID = (state_q == StData) && M_AXI_RVALID;
  assign M_AXIS_TDATA  = M_AXI_RDATA;
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TLAST  = (state_q == StData) && eof_q && (beats_left_q == 20'd1);

  assign M_AXIS_STS_TVALID = (state_q == StStatus);
  assign M_AXIS_STS_TDATA  = (state_q == StStatus) ?
      {!(slverr_q || decerr_q || interr_q), slverr_q, decerr_q, interr_q, tag_q} : 8'h00;

endmodule

// File: tb/tb_acp_mm2s_engine.sv
// Bench for acp_mm2s_engine: table vectors plus random commands against a burst/beat/status
// reference model, with a randomly stalling AXI read slave and stream/status sinks.
module tb_acp_mm2s_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid, cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid, sts_tready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;

  always #5 clk = ~clk;

  acp_mm2s_engine dut (
    .clk(clk), .rst(rst),
    .S_AXIS_CMD_TDATA(cmd_tdata), .S_AXIS_CMD_TVALID(cmd_tvalid), .S_AXIS_CMD_TREADY(cmd_tready),
    .M_AXIS_STS_TDATA(sts_tdata), .M_AXIS_STS_TVALID(sts_tvalid), .M_AXIS_STS_TREADY(sts_tready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARPROT(arprot), .M_AXI_ARCACHE(arcache), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep),
    .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
  );

  typedef struct {
    logic [22:0] btt;
    logic [31:0] saddr;
    logic [3:0]  tag;
    bit          eof;
    bit          typ;
    int          err_beat;
    logic [1:0]  err_resp;
    int          bad_beat;
    int          exp_sts;
  } vec_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [63:0] data; logic last;} beat_t;

  ar_t        exp_ar[$];
  beat_t      exp_beats[$];
  logic [7:0] exp_sts[$];

  int checks = 0;
  int errors = 0;
  int unsigned ar_pct = 50, r_pct = 70, t_pct = 50, s_pct = 70;
  int          g_err_beat = -1, g_bad_beat = -1, cmd_beat = 0;
  logic [1:0]  g_err_resp = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required none", name, act);
  endtask

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic bit is_valid(input vec_t c);
    return (c.btt != 23'd0) && (c.btt[2:0] == 3'd0) && (c.saddr[2:0] == 3'd0) && c.typ;
  endfunction

  function automatic logic [7:0] model_sts(input vec_t c);
    int beats;
    bit s, d, i;
    beats = int'(c.btt >> 3);
    if (!is_valid(c)) return {4'h1, c.tag};
    s = c.err_beat >= 0 && c.err_beat < beats && c.err_resp == 2'b10;
    d = c.err_beat >= 0 && c.err_beat < beats && c.err_resp == 2'b11;
    i = c.bad_beat >= 0 && c.bad_beat < beats;
    return {!(s || d || i), s, d, i, c.tag};
  endfunction

  // Expected AR bursts, stream beats and status for one command.
  task automatic prep(input vec_t c);
    int rem, n, pg;
    logic [31:0] a;
    exp_sts.push_back(c.exp_sts >= 0 ? 8'(c.exp_sts) : model_sts(c));
    if (!is_valid(c)) return;
    rem = int'(c.btt >> 3);
    a   = c.saddr;
    while (rem > 0) begin
      pg = (4096 - int'(a[11:0])) / 8;
      n  = rem;
      if (n > 16) n = 16;
      if (n > pg) n = pg;
      exp_ar.push_back('{a, 8'(n - 1)});
      for (int k = 0; k < n; k++)
        exp_beats.push_back('{mem(a + 32'(8 * k)), c.eof && (rem - k == 1)});
      a   = a + 32'(8 * n);
      rem = rem - n;
    end
  endtask

  task automatic issue(input vec_t c);
    logic [71:0] d;
    bit acc = 0;
    g_err_beat = c.err_beat;
    g_err_resp = c.err_resp;
    g_bad_beat = c.bad_beat;
    cmd_beat   = 0;
    d = 72'({$urandom(), $urandom(), $urandom()});
    d[22:0]  = c.btt;
    d[23]    = c.typ;
    d[30]    = c.eof;
    d[63:32] = c.saddr;
    d[67:64] = c.tag;
    @(posedge clk); #1;
    cmd_tdata  = d;
    cmd_tvalid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_tready;
    end
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
    if (!acc) begin
      fail("cmd_accept_timeout", 64'(c.tag));
      return;
    end
    @(negedge clk);
    chk("check_no_ar", 64'(arvalid), 64'd0);
    chk("check_no_sts", 64'(sts_tvalid), 64'd0);
    @(negedge clk);
    if (is_valid(c)) chk("ar_at_n2", 64'(arvalid), 64'd1);
    else             chk("sts_at_n2", 64'(sts_tvalid), 64'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 4000 && exp_sts.size() != 0; k++) @(negedge clk);
    if (exp_sts.size() != 0) fail("status_timeout", 64'(exp_sts.size()));
    chk("beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("ars_drained", 64'(exp_ar.size()), 64'd0);
  endtask

  // AXI read slave: one burst at a time, random AR/R stalls, injected errors.
  initial begin : slave
    bit ar_hs, r_hs, was_rst, pend, active, last;
    int chk_next, b_len, b_idx;
    logic [31:0] p_addr, b_addr;
    logic [7:0]  p_len;
    ar_t e;
    pend = 0; active = 0; chk_next = 0; b_len = 0; b_idx = 0;
    p_addr = '0; p_len = '0; b_addr = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    forever begin
      @(negedge clk);
      was_rst = rst;
      ar_hs = 0;
      r_hs = 0;
      if (rst) begin
        active = 0; pend = 0; chk_next = 0;
      end else begin
        if (chk_next == 1) chk("ar_after_burst", 64'(arvalid), 64'd1);
        if (chk_next == 2) chk("sts_after_data", 64'(sts_tvalid), 64'd1);
        chk_next = 0;
        if (pend) begin
          chk("arvalid_held", 64'(arvalid), 64'd1);
          chk("araddr_stable", 64'(araddr), 64'(p_addr));
          chk("arlen_stable", 64'(arlen), 64'(p_len));
        end
        pend   = arvalid && !arready;
        p_addr = araddr;
        p_len  = arlen;
        ar_hs  = arvalid && arready;
        r_hs   = rvalid && rready;
        if (ar_hs) begin
          chk("ar_one_outstanding", 64'(active), 64'd0);
          chk("arsize", 64'(arsize), 64'd3);
          chk("arburst", 64'(arburst), 64'd1);
          chk("arprot", 64'(arprot), 64'd2);
          chk("arcache", 64'(arcache), 64'hF);
          if (exp_ar.size() == 0) fail("ar_unexpected", 64'(araddr));
          else begin
            e = exp_ar.pop_front();
            chk("araddr", 64'(araddr), 64'(e.addr));
            chk("arlen", 64'(arlen), 64'(e.len));
          end
          active = 1; b_addr = araddr; b_len = int'(arlen); b_idx = 0;
        end
        if (r_hs) begin
          last = (b_idx == b_len);
          b_idx++;
          cmd_beat++;
          b_addr = b_addr + 32'd8;
          if (last) begin
            active   = 0;
            chk_next = (exp_ar.size() > 0) ? 1 : 2;
          end
        end
      end
      @(posedge clk); #1;
      arready = ($urandom_range(0, 99) < ar_pct);
      if (was_rst) rvalid = 0;
      else if (rvalid && !r_hs) rvalid = 1;
      else if (active && $urandom_range(0, 99) < r_pct) begin
        rvalid = 1;
        rdata  = mem(b_addr);
        rresp  = (cmd_beat == g_err_beat) ? g_err_resp : 2'b00;
        rlast  = (b_idx == b_len) ^ (cmd_beat == g_bad_beat);
      end else rvalid = 0;
    end
  end

  initial begin : stream_sink
    beat_t b;
    tready = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tvalid) begin
          chk("rready_eq_tready", 64'(rready), 64'(tready));
          chk("tkeep", 64'(tkeep), 64'hFF);
        end
        if (tvalid && tready) begin
          if (exp_beats.size() == 0) fail("beat_unexpected", tdata);
          else begin
            b = exp_beats.pop_front();
            chk("tdata", tdata, b.data);
            chk("tlast", 64'(tlast), 64'(b.last));
          end
        end
      end
      @(posedge clk); #1;
      tready = ($urandom_range(0, 99) < t_pct);
    end
  end

  initial begin : status_sink
    bit pend;
    logic [7:0] p, e;
    pend = 0; p = '0;
    sts_tready = 0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else begin
        if (pend) begin
          chk("sts_valid_held", 64'(sts_tvalid), 64'd1);
          chk("sts_stable", 64'(sts_tdata), 64'(p));
        end
        pend = sts_tvalid && !sts_tready;
        p    = sts_tdata;
        if (sts_tvalid && sts_tready) begin
          if (exp_sts.size() == 0) fail("sts_unexpected", 64'(sts_tdata));
          else begin
            e = exp_sts.pop_front();
            chk("sts_tdata", 64'(sts_tdata), 64'(e));
          end
        end
      end
      @(posedge clk); #1;
      sts_tready = ($urandom_range(0, 99) < s_pct);
    end
  end

  initial begin : main
    vec_t tbl[12];
    vec_t c;
    bit seen;
    cmd_tdata  = '0;
    cmd_tvalid = 0;
    tbl[0]  = '{23'd64,  32'h1000_0000, 4'd5,  1, 1, -1, 2'b00, -1, 'h85};
    tbl[1]  = '{23'd256, 32'h0000_0FC0, 4'd1,  1, 1, -1, 2'b00, -1, 'h81};
    tbl[2]  = '{23'd32,  32'h1000_0100, 4'd2,  1, 1,  2, 2'b10, -1, 'h42};
    tbl[3]  = '{23'd32,  32'h1000_0200, 4'd3,  1, 1, -1, 2'b00, -1, 'h83};
    tbl[4]  = '{23'd12,  32'h1000_0000, 4'd4,  1, 1, -1, 2'b00, -1, 'h14};
    tbl[5]  = '{23'd16,  32'h1000_0004, 4'd6,  1, 1, -1, 2'b00, -1, 'h16};
    tbl[6]  = '{23'd0,   32'h1000_0000, 4'd7,  1, 1, -1, 2'b00, -1, 'h17};
    tbl[7]  = '{23'd64,  32'h1000_0000, 4'd8,  1, 0, -1, 2'b00, -1, 'h18};
    tbl[8]  = '{23'd16,  32'h1000_0300, 4'd9,  0, 1, -1, 2'b00, -1, 'h89};
    tbl[9]  = '{23'd64,  32'h1000_0400, 4'd10, 1, 1,  5, 2'b11, -1, 'h2A};
    tbl[10] = '{23'd64,  32'h1000_0500, 4'd11, 1, 1, -1, 2'b00,  1, 'h1B};
    tbl[11] = '{23'd128, 32'hFFFF_FFC0, 4'd12, 1, 1, -1, 2'b00, -1, 'h8C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_tready", 64'(cmd_tready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_sts_tvalid", 64'(sts_tvalid), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_sts_tdata", 64'(sts_tdata), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_cmd_tready", 64'(cmd_tready), 64'd1);

    foreach (tbl[i]) begin
      prep(tbl[i]);
      issue(tbl[i]);
      wait_done();
    end

    // Reset while beats are flowing, then a clean command.
    c = '{23'd64, 32'h3000_0000, 4'd13, 1, 1, -1, 2'b00, -1, -1};
    prep(c);
    issue(c);
    seen = 0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      seen = tvalid && tready;
    end
    if (!seen) fail("data_phase_timeout", 64'(exp_beats.size()));
    @(posedge clk); #1;
    rst = 1;
    exp_ar.delete();
    exp_beats.delete();
    exp_sts.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_sts_tvalid", 64'(sts_tvalid), 64'd0);
    chk("mid_rst_cmd_tready", 64'(cmd_tready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    c = '{23'd40, 32'h3000_0FF0, 4'd14, 1, 1, -1, 2'b00, -1, -1};
    prep(c);
    issue(c);
    wait_done();

    for (int n = 0; n < 25; n++) begin
      ar_pct = $urandom_range(30, 100);
      r_pct  = $urandom_range(30, 100);
      t_pct  = $urandom_range(30, 100);
      s_pct  = $urandom_range(30, 100);
      c.btt      = 23'(8 * $urandom_range(1, 80));
      c.saddr    = 32'h2000_0000 + 32'(8 * $urandom_range(0, 1023));
      c.tag      = 4'($urandom());
      c.eof      = 1'($urandom());
      c.typ      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) c.btt = c.btt + 23'd4;
      if ($urandom_range(0, 9) == 0) c.saddr = c.saddr + 32'd4;
      c.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(c.btt >> 3) - 1)) : -1;
      c.err_resp = 2'($urandom_range(2, 3));
      c.bad_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(c.btt >> 3) - 1)) : -1;
      c.exp_sts  = -1;
      prep(c);
      issue(c);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
